// File: rtl/channel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : channel_packer
//  Purpose  : Takes one sample of INPUT byte-wide channel groups per strobe,
//             discards disabled groups, packs the remaining bytes densely into
//             a DEPTH-byte buffer and emits OUTPUT-byte words under a
//             valid/ready handshake. Supports explicit flush of a partial
//             (zero-padded) word and sticky overflow detection.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        : system clock
//    rst_in       : asynchronous active-low reset
//    cfg_stb_i    : load cfg_i as the disable mask, clear buffer and flags
//    cfg_i        : per-group disable mask (1 = group disabled)
//    stb_i        : sample valid on d_i (cannot be stalled)
//    d_i          : sample, group i on d_i[i*8 +: 8]
//    flush_i      : pulse, emit remaining bytes as a zero-padded word
//    stb_o        : q_o valid
//    ready_i      : consumer accepts q_o this cycle
//    q_o          : packed word, q_o[7:0] is the oldest byte
//    overflow_o   : sticky, a sample was dropped
//    flush_done_o : one-cycle pulse when a flush completes
//    drop_cnt_o   : saturating dropped-sample count (optional)
//  Build option
//    CHANNEL_PACKER_DROP_CNT_EN : when defined, adds drop_cnt_o [15:0]
// ============================================================================
module channel_packer #(
    parameter int INPUT  = 4,
    parameter int OUTPUT = 4,
    parameter int DEPTH  = 16
) (
    input  logic                clk_i,
    input  logic                rst_in,
    input  logic                cfg_stb_i,
    input  logic [INPUT-1:0]    cfg_i,
    input  logic                stb_i,
    input  logic [INPUT*8-1:0]  d_i,
    input  logic                flush_i,
    output logic                stb_o,
    input  logic                ready_i,
    output logic [OUTPUT*8-1:0] q_o,
    output logic                overflow_o,
    output logic                flush_done_o
`ifdef CHANNEL_PACKER_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt_o
`endif
);

    localparam int FW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Byte j of the buffer lives at mem_q[j*8 +: 8]; byte 0 is the oldest.
    // Every byte at or above the fill level is kept at zero, so a partial
    // flush word is zero-padded without extra masking and new bytes can be
    // OR-ed in above the surviving data.
    logic [DEPTH*8-1:0] mem_q,  mem_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [INPUT-1:0]   mask_q, mask_d;
    logic [0:0]         state_q, state_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [DEPTH*8-1:0] packed_v;
    logic [DEPTH*8-1:0] base_v;
    logic               pop;
    logic               partial;
    logic               accept;
    logic               drop;
    int                 fill_int;
    int                 n_en;
    int                 popped;
    int                 rem;

    assign fill_int = int'(fill_q);

    // A short word is only offered while flushing.
    assign partial = (fill_int < OUTPUT);
    assign stb_o   = !partial || ((state_q == ST_FLUSH) && (fill_int != 0));
    assign q_o     = stb_o ? mem_q[OUTPUT*8-1:0] : '0;
    assign pop     = stb_o && ready_i;

    assign overflow_o   = overflow_q;
    assign flush_done_o = done_q;

    // Compact the enabled groups, lowest group index first.
    always_comb begin
        packed_v = '0;
        n_en     = 0;
        for (int g = 0; g < INPUT; g++) begin
            if (!mask_q[g]) begin
                for (int k = 0; k < INPUT; k++) begin
                    if (k == n_en) begin
                        packed_v[k*8 +: 8] = d_i[g*8 +: 8];
                    end
                end
                n_en = n_en + 1;
            end
        end
    end

    always_comb begin
        popped     = 0;
        base_v     = mem_q;
        if (pop) begin
            if (partial) begin
                popped = fill_int;
                base_v = '0;
            end else begin
                popped = OUTPUT;
                base_v = mem_q >> (OUTPUT * 8);
            end
        end
        rem = fill_int - popped;

        // Room is judged after this cycle's pop; a sample that does not fit
        // is dropped whole. Samples are ignored entirely while flushing or
        // when every group is disabled.
        accept = (state_q == ST_RUN) && stb_i && !cfg_stb_i && (n_en != 0)
                 && ((rem + n_en) <= DEPTH);
        drop   = (state_q == ST_RUN) && stb_i && !cfg_stb_i && (n_en != 0)
                 && ((rem + n_en) > DEPTH);

        mem_d      = accept ? (base_v | (packed_v << (rem * 8))) : base_v;
        fill_d     = FW'(accept ? (rem + n_en) : rem);
        mask_d     = mask_q;
        overflow_d = overflow_q | drop;
        done_d     = 1'b0;
        state_d    = state_q;

        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Covers both the final pop and entering with nothing buffered.
                if (rem == 0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Configuration overrides everything else in the same cycle.
        if (cfg_stb_i) begin
            mem_d      = '0;
            fill_d     = '0;
            mask_d     = cfg_i;
            overflow_d = 1'b0;
            done_d     = 1'b0;
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            mem_q      <= '0;
            fill_q     <= '0;
            mask_q     <= '0;
            state_q    <= ST_RUN;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            fill_q     <= fill_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

`ifdef CHANNEL_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            drop_cnt_q <= '0;
        end else if (cfg_stb_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
`default_nettype wire
